// File: rtl/gf2m_poly_reduce_if.sv
// rtl/gf2m_poly_reduce_if.sv - handshake bundle between product source, reducer and result sink
// Ports:
//   in_valid/in_ready/prod   : product side (2M-bit carry-less product)
//   out_valid/out_ready/r    : result side (M-bit field element)
// Modports: master = product source / result sink, slave = reducer.
interface gf2m_poly_reduce_if #(
    parameter int M = 256
);
    logic             in_valid;
    logic             in_ready;
    logic [2*M-1:0]   prod;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     r;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/gf2m_poly_reduce.sv
// rtl/gf2m_poly_reduce.sv - digit-serial reduction of a 2M-bit GF(2)[x] product mod x^M + POLY_LOW
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gf2m_poly_reduce_if.slave (in_valid/in_ready/prod, out_valid/out_ready/r)
// A product is accepted in IDLE, folded DIGIT bits per cycle for N = M/DIGIT
// cycles, then held in DONE until the sink takes it.
module gf2m_poly_reduce #(
    parameter int           M        = 256,
    parameter int           DIGIT    = 8,
    parameter logic [M-1:0] POLY_LOW = M'((1 << 10) | (1 << 5) | (1 << 2) | 1)
) (
    input  logic                clk,
    input  logic                rst,
    gf2m_poly_reduce_if.slave   bus
);
    localparam int N  = M / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Full modulus zero-extended to the accumulator width.
    localparam logic [2*M-1:0] MODULUS = {{(M - 1){1'b0}}, 1'b1, POLY_LOW};

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t          state;
    logic [2*M-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    r_q;
    logic            out_valid_q;

    logic [2*M-1:0]  folded;
    logic [2*M-1:0]  shifted;

    // The accumulator is shifted left by DIGIT after every fold, so the digit
    // being reduced always sits in the top DIGIT bits and every fold uses a
    // constant shift. After N cycles the total shift is exactly M, leaving the
    // reduced value in the upper half. Folding bit j with the modulus is valid
    // because the real degree of every top-digit bit stays >= M throughout.
    always_comb begin
        folded = acc;
        for (int j = 2 * M - 1; j >= 2 * M - DIGIT; j--) begin
            if (folded[j]) begin
                folded = folded ^ (MODULUS << (j - M));
            end
        end
        shifted = folded << DIGIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc   <= bus.prod;
                        cnt   <= '0;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    acc <= shifted;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        r_q         <= shifted[2*M-1:M];
                        out_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // r_q is deliberately left untouched after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
endmodule

// File: tb/tb_gf2m_poly_reduce.sv
// tb/tb_gf2m_poly_reduce.sv - self-checking bench for gf2m_poly_reduce against a polynomial-mod model
module tb_gf2m_poly_reduce;
    localparam int M     = 256;
    localparam int DIGIT = 8;
    localparam int N     = M / DIGIT;
    localparam logic [M-1:0] POLY_LOW = 256'h425;
    localparam int NRAND = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gf2m_poly_reduce_if #(.M(M)) bus();

    gf2m_poly_reduce #(.M(M), .DIGIT(DIGIT), .POLY_LOW(POLY_LOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic rand_phase = 1'b0;
    logic rnd_ready  = 1'b0;
    logic dir_ready  = 1'b0;
    assign bus.out_ready = rand_phase ? rnd_ready : dir_ready;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Schoolbook long division over GF(2): cancel each set bit from the top.
    function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] p);
        logic [2*M-1:0] v;
        logic [2*M-1:0] modl;
        v    = p;
        modl = {{(M - 1){1'b0}}, 1'b1, POLY_LOW};
        for (int i = 2 * M - 1; i >= M; i--) begin
            if (v[i]) v = v ^ (modl << (i - M));
        end
        return v[M-1:0];
    endfunction

    // Scoreboard: expected results and accept cycles of accepted products.
    logic [M-1:0] exp_q[$];
    int           acc_q[$];
    bit           seen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            seen = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%h expected=none", bus.r);
                end else begin
                    if (!seen) begin
                        check_int("latency", cyc - acc_q[0], N);
                        seen = 1'b1;
                    end
                    check("r_vs_model", bus.r, exp_q[0]);
                    check("in_ready_in_done", M'(bus.in_ready), '0);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mod(bus.prod));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic run_one(input string name, input logic [2*M-1:0] p,
                           input logic [M-1:0] exp, input int stall);
        int t;
        bus.prod     = p;
        bus.in_valid = 1'b1;
        dir_ready    = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < N + 5) begin
            @(posedge clk); #1;
            t++;
        end
        check_int({name, "_latency"}, t, N);
        check({name, "_r"}, bus.r, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({name, "_stall_r"}, bus.r, exp);
            check({name, "_stall_valid"}, M'(bus.out_valid), M'(1));
            check({name, "_stall_in_ready"}, M'(bus.in_ready), '0);
        end
        dir_ready = 1'b1;
        @(posedge clk); #1;
        dir_ready = 1'b0;
        check({name, "_valid_drop"}, M'(bus.out_valid), '0);
        check({name, "_in_ready_back"}, M'(bus.in_ready), M'(1));
        check({name, "_r_kept"}, bus.r, exp);
    endtask

    initial begin : main
        logic [2*M-1:0] p256;
        logic [2*M-1:0] p511;
        logic [M-1:0]   r511;
        logic [2*M-1:0] p;
        int             guard;
        bit             sampled;

        bus.in_valid = 1'b0;
        bus.prod     = '0;
        p256 = '0; p256[256] = 1'b1;
        p511 = '0; p511[511] = 1'b1;
        r511 = 256'h8001A; r511[255] = 1'b1;

        check("model_x256", ref_mod(p256), 256'h425);
        check("model_x511", ref_mod(p511), r511);
        check("model_small", ref_mod(512'hDEADBEEF), 256'hDEADBEEF);

        repeat (3) @(posedge clk);
        #1;
        check("reset_r", bus.r, '0);
        check("reset_out_valid", M'(bus.out_valid), '0);
        check("reset_in_ready", M'(bus.in_ready), M'(1));
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", M'(bus.in_ready), M'(1));
        @(posedge clk); #1;

        run_one("x256", p256, 256'h425, 0);
        run_one("small", 512'hDEADBEEF, 256'hDEADBEEF, 0);
        run_one("zero", '0, '0, 0);
        run_one("x511_bp", p511, r511, 10);

        // Abort a reduction of x^511 after cnt reaches 15.
        bus.prod     = p511;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_r", bus.r, '0);
        check("abort_out_valid", M'(bus.out_valid), '0);
        check("abort_in_ready", M'(bus.in_ready), M'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_one("after_abort", p256, 256'h425, 0);

        // Random regression with back-to-back in_valid and random out_ready.
        rand_phase = 1'b1;
        for (int k = 0; k < NRAND; k++) begin
            for (int w = 0; w < 16; w++) p[w*32 +: 32] = $urandom;
            p[2*M-1] = 1'b0;
            bus.prod     = p;
            bus.in_valid = 1'b1;
            guard = 0;
            sampled = 1'b0;
            while (!sampled && guard < 200) begin
                sampled = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!sampled) begin
                total++;
                bad++;
                $display("FAIL accept_timeout actual=no_accept expected=accept item=%0d", k);
                k = NRAND;
            end
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_int("drain_queue", exp_q.size(), 0);
        rand_phase = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
